// File: rtl/alu_tile_input_arbiter.sv
// Five-port (N/E/S/W/host) input arbiter for an ALU tile: round-robin with sticky LOCK ownership,
// single output register stage. Define ALU_ARB_STATS_EN to build the saturating per-port grant counters.
module alu_tile_input_arbiter #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            req_valid,
    output logic [4:0]            req_ready,
    input  logic [5*DATA_W-1:0]   req_a,
    input  logic [5*DATA_W-1:0]   req_b,
    input  logic [5*CTRL_W-1:0]   req_ctrl,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [CTRL_W-1:0]     alu_ctrl,
    output logic                  alu_valid,
    input  logic                  alu_ready,
    output logic [2:0]            alu_src,
    output logic [5*16-1:0]       grant_cnt
);

    typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [2:0]        owner_q, owner_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;

    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic              alu_valid_q, alu_valid_d;
    logic [2:0]        alu_src_q, alu_src_d;

    logic [DATA_W-1:0] port_a    [5];
    logic [DATA_W-1:0] port_b    [5];
    logic [CTRL_W-1:0] port_ctrl [5];
    logic [2:0]        cand_idx  [5];

    logic              load_en;
    logic              win_found;
    logic [2:0]        win_idx;
    logic              win_lock;
    logic              accept;

    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        return (idx >= 3'd4) ? 3'd0 : idx + 3'd1;
    endfunction

    // Unpack the flat port buses and build the round-robin scan order starting at rr_ptr.
    for (genvar gi = 0; gi < 5; gi++) begin : g_port
        logic [3:0] sum;
        assign port_a[gi]    = req_a[gi*DATA_W +: DATA_W];
        assign port_b[gi]    = req_b[gi*DATA_W +: DATA_W];
        assign port_ctrl[gi] = req_ctrl[gi*CTRL_W +: CTRL_W];
        assign sum           = {1'b0, rr_ptr_q} + 4'(gi);
        assign cand_idx[gi]  = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
    end

    assign load_en = !alu_valid_q || alu_ready;

    // Winner selection: only the owner may win while locked; otherwise the first valid
    // port at or after rr_ptr (descending loop so the lowest offset wins).
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        if (state_q == ST_LOCKED) begin
            win_found = req_valid[owner_q];
            win_idx   = owner_q;
        end else begin
            for (int k = 4; k >= 0; k--) begin
                if (req_valid[cand_idx[k]]) begin
                    win_found = 1'b1;
                    win_idx   = cand_idx[k];
                end
            end
        end
    end

    assign win_lock = port_ctrl[win_idx][CTRL_W-1];
    assign accept   = win_found && load_en && !rst;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_UNLOCKED;
            owner_q  <= 3'd0;
            rr_ptr_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // FSM: next state. rr_ptr only advances when the arbiter is (or becomes) unlocked.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (win_lock) begin
                state_d = ST_LOCKED;
                owner_d = win_idx;
            end else begin
                state_d  = ST_UNLOCKED;
                rr_ptr_d = next_ptr(win_idx);
            end
        end
    end

    // FSM: outputs
    always_comb begin
        req_ready = 5'd0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Output register stage; data holds when nothing new is loaded.
    always_comb begin
        alu_valid_d = load_en ? accept : alu_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_src_d   = alu_src_q;
        if (accept) begin
            alu_a_d    = port_a[win_idx];
            alu_b_d    = port_b[win_idx];
            alu_ctrl_d = port_ctrl[win_idx];
            alu_src_d  = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            alu_src_q   <= 3'd0;
        end else begin
            alu_valid_q <= alu_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_src_q   <= alu_src_d;
        end
    end

    assign alu_valid = alu_valid_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign alu_src   = alu_src_q;

`ifdef ALU_ARB_STATS_EN
    for (genvar gi = 0; gi < 5; gi++) begin : g_stats
        logic [15:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (accept && (win_idx == 3'(gi)) && (cnt_q != 16'hFFFF)) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= 16'd0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
        assign grant_cnt[gi*16 +: 16] = cnt_q;
    end
`else
    assign grant_cnt = '0;
`endif

endmodule
